// File: rtl/knight_rider_pkg.sv
// Shared types and constants for the Knight Rider LED scanner.
// Trail feature selected by KNIGHT_RIDER_TRAIL_EN (see knight_rider_ctrl).
package knight_rider_pkg;

   localparam int MAX_LEDS        = 10;
   localparam int POS_W           = 4;
   localparam int DEF_TICK_CYCLES = 2500000;

   typedef enum logic [1:0] {
      IDLE,
      SCAN_UP,
      SCAN_DOWN,
      PAUSE
   } kr_state_t;

   typedef logic [POS_W-1:0] pos_t;

   function automatic logic [MAX_LEDS-1:0] pos_onehot(input pos_t p);
      return MAX_LEDS'(1) << p;
   endfunction

endpackage

// File: rtl/knight_rider_if.sv
// Control/status bundle of the LED scanner; master drives commands, slave is the controller.
interface knight_rider_if
   import knight_rider_pkg::*;
#(
   parameter int NUM_LEDS = MAX_LEDS
);

   logic                start;
   logic                stop;
   logic [2:0]          speed;
   logic [NUM_LEDS-1:0] LEDR;
   logic                busy;
   logic                dir;
   logic [7:0]          sweep_count;

   modport master (
      output start, stop, speed,
      input  LEDR, busy, dir, sweep_count
   );

   modport slave (
      input  start, stop, speed,
      output LEDR, busy, dir, sweep_count
   );

endinterface

// File: rtl/kr_tick_gen.sv
// Step prescaler: one-cycle tick every TICK_CYCLES*(speed+1) clocks, restarting on clear or speed change.
module kr_tick_gen
   import knight_rider_pkg::*;
#(
   parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic [2:0] speed,
   output logic       tick
);

   localparam int CNT_W = $clog2(TICK_CYCLES * 8);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] limit;
   logic [2:0]       speed_q;
   logic             restart;

   assign limit   = CNT_W'(TICK_CYCLES * (int'(speed) + 1) - 1);
   assign restart = clear || (speed != speed_q);
   assign tick    = !restart && (cnt_q == limit);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         speed_q <= '0;
      end else begin
         speed_q <= speed;
         if (restart || tick)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/knight_rider_ctrl.sv
// Knight Rider LED scanner: FSM bouncing a lit LED between the ends of LEDR.
// Define KNIGHT_RIDER_TRAIL_EN to also light the two previously visited positions.
module knight_rider_ctrl
   import knight_rider_pkg::*;
#(
   parameter int NUM_LEDS    = MAX_LEDS,
   parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   knight_rider_if.slave  bus
);

   if (NUM_LEDS < 3 || NUM_LEDS > MAX_LEDS) begin : g_bad_num_leds
      $error("knight_rider_ctrl: NUM_LEDS must be in 3..10");
   end

   kr_state_t           state_q, state_d;
   pos_t                pos_q, pos_d;
   logic                dir_q, dir_d;
   logic [7:0]          sweep_q, sweep_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                busy_q, busy_d;
   logic                step;
   logic                home;
   logic                tick;
   logic                tick_clear;
   logic [NUM_LEDS-1:0] lit;

   // Prescaler runs only while actively scanning; every start begins a full period.
   assign tick_clear = bus.start || (state_q == IDLE) || (state_q == PAUSE);

   kr_tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick_gen (
      .clk   (CLOCK_50),
      .rst   (reset),
      .clear (tick_clear),
      .speed (bus.speed),
      .tick  (tick)
   );

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      sweep_d = sweep_q;
      step    = 1'b0;
      home    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = SCAN_UP;
               dir_d   = 1'b1;
               home    = 1'b1;
            end
         end
         SCAN_UP: begin
            if (bus.stop) begin
               state_d = PAUSE;
            end else if (tick) begin
               step = 1'b1;
               if (pos_q == pos_t'(NUM_LEDS - 2)) begin
                  state_d = SCAN_DOWN;
                  dir_d   = 1'b0;
               end
            end
         end
         SCAN_DOWN: begin
            if (bus.stop) begin
               state_d = PAUSE;
            end else if (tick) begin
               step = 1'b1;
               if (pos_q == pos_t'(1)) begin
                  state_d = SCAN_UP;
                  dir_d   = 1'b1;
                  sweep_d = sweep_q + 8'd1;
               end
            end
         end
         PAUSE: begin
            if (bus.stop) begin
               state_d = IDLE;
               dir_d   = 1'b1;
               home    = 1'b1;
            end else if (bus.start) begin
               state_d = dir_q ? SCAN_UP : SCAN_DOWN;
            end
         end
         default: begin
            state_d = IDLE;
            home    = 1'b1;
         end
      endcase

      pos_d = pos_q;
      if (home)
         pos_d = '0;
      else if (step)
         pos_d = dir_q ? pos_q + pos_t'(1) : pos_q - pos_t'(1);
   end

`ifdef KNIGHT_RIDER_TRAIL_EN
   pos_t prev1_q, prev1_d;
   pos_t prev2_q, prev2_d;

   always_comb begin
      prev1_d = prev1_q;
      prev2_d = prev2_q;
      if (home) begin
         prev1_d = '0;
         prev2_d = '0;
      end else if (step) begin
         prev1_d = pos_q;
         prev2_d = prev1_q;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         prev1_q <= '0;
         prev2_q <= '0;
      end else begin
         prev1_q <= prev1_d;
         prev2_q <= prev2_d;
      end
   end

   always_comb begin
      lit = NUM_LEDS'(pos_onehot(pos_d)) | NUM_LEDS'(pos_onehot(prev1_d))
          | NUM_LEDS'(pos_onehot(prev2_d));
   end
`else
   always_comb begin
      lit = NUM_LEDS'(pos_onehot(pos_d));
   end
`endif

   // Outputs are computed from next-state values so they are plain registers.
   always_comb begin
      busy_d = (state_d != IDLE);
      led_d  = (state_d == IDLE) ? '0 : lit;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pos_q   <= '0;
         dir_q   <= 1'b1;
         sweep_q <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         sweep_q <= sweep_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.LEDR        = led_q;
   assign bus.busy        = busy_q;
   assign bus.dir         = dir_q;
   assign bus.sweep_count = sweep_q;

endmodule

// File: doc/knight_rider_ctrl.md
KNIGHT_RIDER_CTRL -- requirements
Module: knight_rider_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 10: LED count; legal range 3..10.
REQ-002 Parameter TICK_CYCLES, default 2500000: base step period in clocks (50 ms at 50 MHz).
REQ-003 CLOCK_50  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  synchronous one-cycle pulse: begin or resume the scan.
REQ-006 stop  input  1  synchronous one-cycle pulse: pause, or clear when already paused.
REQ-007 speed  input  3  step period select; period = TICK_CYCLES*(speed+1).
REQ-008 LEDR  output  NUM_LEDS  LED drive; bit i lit = LED i on.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 dir  output  1  1 = scanning up (toward MSB), 0 = scanning down.
REQ-011 sweep_count  output  8  count of completed round trips; wraps 255->0.

Function
REQ-012 FSM states SHALL be exactly: IDLE, SCAN_UP, SCAN_DOWN, PAUSE.
REQ-013 The prescaler SHALL assert a one-cycle tick when its count reaches TICK_CYCLES*(speed+1)-1, then restart from 0.
REQ-014 The prescaler SHALL clear to 0 on start, on any change of speed, and whenever the FSM is in IDLE or PAUSE.
REQ-015 IDLE + start: SHALL enter SCAN_UP with pos=0 and dir=1; LEDR SHALL equal 1 on the next cycle.
REQ-016 SCAN_UP on tick: pos SHALL increment; if pos was NUM_LEDS-2, the FSM SHALL enter SCAN_DOWN and dir SHALL go to 0.
REQ-017 SCAN_DOWN on tick: pos SHALL decrement; if pos was 1, the FSM SHALL enter SCAN_UP, dir SHALL go to 1, and sweep_count SHALL increment.
REQ-018 Position 0 and position NUM_LEDS-1 SHALL each be held for exactly one step period (no double dwell at the ends).
REQ-019 SCAN_UP/SCAN_DOWN + stop: SHALL enter PAUSE; pos, dir and LEDR SHALL hold.
REQ-020 PAUSE + start: SHALL return to the state selected by dir, with a full new step period before the next move.
REQ-021 PAUSE + stop: SHALL enter IDLE; LEDR SHALL be 0 and pos SHALL be 0; sweep_count SHALL hold.
REQ-022 start and stop asserted in the same cycle: stop SHALL win.
REQ-023 stop and tick in the same cycle: stop SHALL win, and pos SHALL not advance.
REQ-024 start while scanning SHALL be ignored; stop in IDLE SHALL be ignored.
REQ-025 Without trail (see REQ-030), LEDR SHALL be one-hot at pos in scan and pause states, and 0 in IDLE.
REQ-026 All outputs SHALL be registered; the LEDR update SHALL occur in the cycle after the tick.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE with LEDR=0, busy=0, dir=1, sweep_count=0, pos=0, prescaler=0, and trail history cleared.
REQ-028 Reset asserted mid-scan SHALL take effect immediately (asynchronously); after release, the block SHALL wait for start.

Configuration
REQ-029 Macro KNIGHT_RIDER_TRAIL_EN selects the trail feature.
REQ-030 With KNIGHT_RIDER_TRAIL_EN defined: LEDR SHALL be one-hot(pos) OR one-hot(prev1) OR one-hot(prev2), where prev1 and prev2 are the last two positions, shifted on each step; history SHALL clear on entering IDLE and on start from IDLE.
REQ-031 With KNIGHT_RIDER_TRAIL_EN undefined: no history registers SHALL exist, and REQ-025 SHALL apply.

Structure
REQ-032 A shared package knight_rider_pkg SHALL hold the FSM state enum typedef, the LED-width constant, and the default TICK_CYCLES.
REQ-033 The prescaler SHALL be a sub-module kr_tick_gen (inputs: clear, speed; output: tick); the FSM and LED drive SHALL remain in knight_rider_ctrl.

Verification (TICK_CYCLES=4, NUM_LEDS=10)
REQ-034 Reset, then start, speed=0 -> LEDR=0x001; 0x002 after 4 clocks; reaches 0x200 after 36 clocks, then 0x100 after 4 more.
REQ-035 Full round trip -> sweep_count 0->1 on the 0x002->0x001 step; 256 trips -> wraps to 0.
REQ-036 stop at LEDR=0x010 -> holds 0x010 for 20 clocks with busy=1; start -> 0x020 (if dir=1) 4 clocks later; stop twice -> LEDR=0, busy=0.
REQ-037 start and stop in the same cycle from IDLE -> stays in IDLE; stop coincident with tick -> LEDR unchanged.
REQ-038 speed=3 -> step every 16 clocks; speed change mid-period -> prescaler restarts, next step 4*(new speed+1) clocks later.
REQ-039 KNIGHT_RIDER_TRAIL_EN defined, scanning up at pos 5 -> LEDR=0x038; reset mid-scan -> LEDR=0 immediately, sweep_count=0.
